// File: rtl/maxpool_frame_sequencer.sv
// Frame sequencer for the 3-channel 2x2/stride-2 max-pool stage: streams one map from the
// source buffer into the pool stage row by row and collects pooled results into the destination.
`timescale 1ns/1ps
module maxpool_frame_sequencer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DISP_WIDTH = 26,
    parameter int unsigned SRC_AW     = 10,
    parameter int unsigned DST_AW     = 8,
    parameter int unsigned ROW_GAP    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause_req,
    output logic                    busy,
    output logic                    done,
    output logic                    src_rd_en,
    output logic [SRC_AW-1:0]       src_addr,
    input  logic [3*DATA_WIDTH-1:0] src_rdata,
    output logic [DATA_WIDTH-1:0]   pool_data_1,
    output logic [DATA_WIDTH-1:0]   pool_data_2,
    output logic [DATA_WIDTH-1:0]   pool_data_3,
    output logic                    pool_valid,
    input  logic [DATA_WIDTH-1:0]   pool_out_1,
    input  logic [DATA_WIDTH-1:0]   pool_out_2,
    input  logic [DATA_WIDTH-1:0]   pool_out_3,
    input  logic                    pool_out_valid,
    output logic                    dst_we,
    output logic [DST_AW-1:0]       dst_addr,
    output logic [3*DATA_WIDTH-1:0] dst_wdata
);

    localparam int unsigned CntW     = (DISP_WIDTH > 2) ? $clog2(DISP_WIDTH) : 1;
    localparam int unsigned OutCount = (DISP_WIDTH / 2) * (DISP_WIDTH / 2);
    // A pause-only gap still lasts one cycle.
    localparam int unsigned GapLen   = (ROW_GAP > 0) ? ROW_GAP : 1;

    typedef enum logic [2:0] {StIdle, StRow, StGap, StTail, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         col_q, col_d;
    logic [CntW-1:0]         row_q, row_d;
    logic [SRC_AW-1:0]       src_addr_q, src_addr_d;
    logic [3:0]              gap_q, gap_d;
    logic                    pool_valid_q;
    logic                    dst_we_q;
    logic [DST_AW-1:0]       dst_addr_q;
    logic [3*DATA_WIDTH-1:0] dst_wdata_q;

    logic last_col, last_row, gap_done, final_write, capture;

    assign last_col    = (col_q == CntW'(DISP_WIDTH - 1));
    assign last_row    = (row_q == CntW'(DISP_WIDTH - 1));
    assign gap_done    = (gap_q == 4'(GapLen - 1));
    assign final_write = dst_we_q && (dst_addr_q == DST_AW'(OutCount - 1));
    assign capture     = pool_valid_q && pool_out_valid;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        src_addr_d = src_addr_q;
        gap_d      = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRow;
                    col_d      = '0;
                    row_d      = '0;
                    src_addr_d = '0;
                end
            end
            StRow: begin
                // Address holds on the final pixel so it never wraps.
                if (!(last_col && last_row)) begin
                    src_addr_d = src_addr_q + SRC_AW'(1);
                end
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        state_d = StTail;
                    end else begin
                        row_d = row_q + CntW'(1);
                        if ((ROW_GAP != 0) || pause_req) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end
                    end
                end else begin
                    col_d = col_q + CntW'(1);
                end
            end
            StGap: begin
                if (!gap_done) begin
                    gap_d = gap_q + 4'd1;
                end else if (!pause_req) begin
                    state_d = StRow;
                end
            end
            StTail: begin
                if (final_write) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            src_addr_q   <= '0;
            gap_q        <= '0;
            pool_valid_q <= 1'b0;
            dst_we_q     <= 1'b0;
            dst_addr_q   <= '0;
            dst_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            src_addr_q   <= src_addr_d;
            gap_q        <= gap_d;
            pool_valid_q <= src_rd_en;
            dst_we_q     <= capture;
            if (capture) begin
                dst_wdata_q <= {pool_out_3, pool_out_2, pool_out_1};
            end
            if ((state_q == StIdle) && start) begin
                dst_addr_q <= '0;
            end else if (dst_we_q) begin
                dst_addr_q <= dst_addr_q + DST_AW'(1);
            end
        end
    end

    assign src_rd_en  = (state_q == StRow);
    assign src_addr   = src_addr_q;
    assign busy       = (state_q == StRow) || (state_q == StGap) || (state_q == StTail);
    assign done       = (state_q == StDone);
    assign pool_valid = pool_valid_q;

    // Buffer output is already registered; gating only keeps the bus quiet outside beats.
    assign pool_data_1 = pool_valid_q ? src_rdata[DATA_WIDTH-1:0] : '0;
    assign pool_data_2 = pool_valid_q ? src_rdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign pool_data_3 = pool_valid_q ? src_rdata[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;

    assign dst_we    = dst_we_q;
    assign dst_addr  = dst_addr_q;
    assign dst_wdata = dst_wdata_q;

endmodule

// File: tb/tb_maxpool_frame_sequencer.sv
// Bench for maxpool_frame_sequencer: two instances (ROW_GAP 0 and 3), a source buffer and
// pool-stage stand-in, and a scoreboard checked by a monitor on every destination write.
`timescale 1ns/1ps
module tb_maxpool_frame_sequencer;

    localparam int W    = 26;
    localparam int NOUT = 169;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]        start, pause_req, busy, done, src_rd_en, pool_valid, pool_out_valid, dst_we;
    logic [1:0][9:0]   src_addr;
    logic [1:0][71:0]  src_rdata, dst_wdata;
    logic [1:0][23:0]  pd1, pd2, pd3, po1, po2, po3;
    logic [1:0][7:0]   dst_addr;

    maxpool_frame_sequencer #(.ROW_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .pause_req(pause_req[0]),
        .busy(busy[0]), .done(done[0]), .src_rd_en(src_rd_en[0]), .src_addr(src_addr[0]),
        .src_rdata(src_rdata[0]), .pool_data_1(pd1[0]), .pool_data_2(pd2[0]),
        .pool_data_3(pd3[0]), .pool_valid(pool_valid[0]), .pool_out_1(po1[0]),
        .pool_out_2(po2[0]), .pool_out_3(po3[0]), .pool_out_valid(pool_out_valid[0]),
        .dst_we(dst_we[0]), .dst_addr(dst_addr[0]), .dst_wdata(dst_wdata[0])
    );

    maxpool_frame_sequencer #(.ROW_GAP(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .pause_req(pause_req[1]),
        .busy(busy[1]), .done(done[1]), .src_rd_en(src_rd_en[1]), .src_addr(src_addr[1]),
        .src_rdata(src_rdata[1]), .pool_data_1(pd1[1]), .pool_data_2(pd2[1]),
        .pool_data_3(pd3[1]), .pool_valid(pool_valid[1]), .pool_out_1(po1[1]),
        .pool_out_2(po2[1]), .pool_out_3(po3[1]), .pool_out_valid(pool_out_valid[1]),
        .dst_we(dst_we[1]), .dst_addr(dst_addr[1]), .dst_wdata(dst_wdata[1])
    );

    function automatic logic [71:0] word(input int a);
        return {24'(a + 2000), 24'(a + 1000), 24'(a)};
    endfunction

    function automatic logic [71:0] cmax(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] r;
        for (int c = 0; c < 3; c++)
            r[c*24 +: 24] = (a[c*24 +: 24] > b[c*24 +: 24]) ? a[c*24 +: 24] : b[c*24 +: 24];
        return r;
    endfunction

    // Source buffer with one-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_rdata <= '0;
        else for (int i = 0; i < 2; i++)
            if (src_rd_en[i]) src_rdata[i] <= word(int'(src_addr[i]));
    end

    // Pool-stage stand-in: raster counters, one line of horizontal maxima, previous beat.
    int          pcol[2], prow[2];
    logic [71:0] prev[2];
    logic [71:0] line_buf[2][13];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pcol[i] <= 0;
                prow[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pool_valid[i]) begin
                    prev[i] <= {pd3[i], pd2[i], pd1[i]};
                    if (prow[i] % 2 == 0 && pcol[i] % 2 == 1)
                        line_buf[i][pcol[i]/2] <= cmax({pd3[i], pd2[i], pd1[i]}, prev[i]);
                    if (pcol[i] == W - 1) begin
                        pcol[i] <= 0;
                        prow[i] <= (prow[i] == W - 1) ? 0 : prow[i] + 1;
                    end else begin
                        pcol[i] <= pcol[i] + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        pool_out_valid = '0;
        po1 = '0;
        po2 = '0;
        po3 = '0;
        for (int i = 0; i < 2; i++) begin
            pool_out_valid[i] = pool_valid[i] && (prow[i] % 2 == 1) && (pcol[i] % 2 == 1);
            {po3[i], po2[i], po1[i]} =
                cmax(cmax({pd3[i], pd2[i], pd1[i]}, prev[i]), line_buf[i][pcol[i]/2]);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check80(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard entries are {dst_addr, dst_wdata}.
    logic [79:0] exp_q0[$];
    logic [79:0] exp_q1[$];
    logic [71:0] dst_mem0[256];

    int rd_first[2], rd_last[2], pv_first[2], pv_last[2], we_last[2], we_cnt[2];
    int done_cnt[2], done_cyc[2], runs[2], first_run[2];
    int run[2] = '{0, 0};
    logic done_busy[2];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run[i] = 0;
            end else begin
                if (src_rd_en[i]) begin
                    if (rd_first[i] < 0) rd_first[i] = cyc;
                    rd_last[i] = cyc;
                end
                if (pool_valid[i]) begin
                    if (pv_first[i] < 0) pv_first[i] = cyc;
                    pv_last[i] = cyc;
                    run[i]++;
                end else if (run[i] > 0) begin
                    runs[i]++;
                    if (first_run[i] < 0) first_run[i] = run[i];
                    check_int("pool_valid run not whole rows", run[i] % W, 0);
                    run[i] = 0;
                end
                if (dst_we[i]) begin
                    we_cnt[i]++;
                    we_last[i] = cyc;
                    if (i == 0) dst_mem0[dst_addr[0]] = dst_wdata[0];
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        check_int("dst write with empty scoreboard", 1, 0);
                    end else begin
                        logic [79:0] want;
                        want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check80("dst write {addr,data}", {dst_addr[i], dst_wdata[i]}, want);
                    end
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                    done_busy[i] = busy[i];
                end
            end
        end
    end

    task automatic clear_stats(input int i);
        rd_first[i] = -1; rd_last[i] = -1; pv_first[i] = -1; pv_last[i] = -1;
        we_last[i] = -1; we_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
        runs[i] = 0; first_run[i] = -1; done_busy[i] = 1'b1;
    endtask

    task automatic push_frame(input int i);
        for (int k = 0; k < NOUT; k++) begin
            int a;
            logic [79:0] e;
            a = (2 * (k / 13) + 1) * W + 2 * (k % 13) + 1;
            e = {8'(k), word(a)};
            if (i == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    endtask

    // Called at a negedge; start is high for exactly the cycle returned in t0.
    task automatic launch(input int i, output int t0);
        clear_stats(i);
        push_frame(i);
        if (i == 0) for (int k = 0; k < 256; k++) dst_mem0[k] = '0;
        start[i] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (n < budget && !done[i]) begin
            @(negedge clk);
            n++;
        end
        if (!done[i]) check_int("done timeout", 0, 1);
    endtask

    task automatic check_zero(input int i, input string tag);
        check_int({tag, " control outputs"},
                  {busy[i], done[i], src_rd_en[i], pool_valid[i], dst_we[i]}, 0);
        check_int({tag, " src_addr"}, src_addr[i], 0);
        check_int({tag, " dst_addr"}, dst_addr[i], 0);
        check80({tag, " pool_data"}, {8'h0, pd3[i], pd2[i], pd1[i]}, 80'h0);
        check80({tag, " dst_wdata"}, {8'h0, dst_wdata[i]}, 80'h0);
    endtask

    task automatic frame_end(input int i, input int t0, input int done_off, input string tag);
        check_int({tag, " done cycle"}, done_cyc[i] - t0, done_off);
        check_int({tag, " busy at done"}, done_busy[i], 0);
        check_int({tag, " write count"}, we_cnt[i], NOUT);
        check_int({tag, " done count"}, done_cnt[i], 1);
        check_int({tag, " scoreboard left"}, (i == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    task automatic check_dst_values(input string tag);
        check_int({tag, " dst[0] ch1"}, dst_mem0[0][23:0], 27);
        check_int({tag, " dst[1] ch1"}, dst_mem0[1][23:0], 29);
        check_int({tag, " dst[168] ch1"}, dst_mem0[168][23:0], 675);
        check_int({tag, " dst[168] ch3"}, dst_mem0[168][71:48], 2675);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        start = '0;
        pause_req = '0;
        clear_stats(0);
        clear_stats(1);
        repeat (3) @(negedge clk);
        check_zero(0, "in reset");
        check_zero(1, "in reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero(0, "idle after reset");

        // Basic frame with exact latency.
        launch(0, t0);
        wait_done(0, 1000);
        @(negedge clk);
        frame_end(0, t0, 679, "basic");
        check_int("basic src_rd_en first", rd_first[0] - t0, 1);
        check_int("basic src_rd_en last", rd_last[0] - t0, 676);
        check_int("basic pool_valid first", pv_first[0] - t0, 2);
        check_int("basic pool_valid last", pv_last[0] - t0, 677);
        check_int("basic last dst_we", we_last[0] - t0, 678);
        check_int("basic pool_valid runs", runs[0], 1);
        check_dst_values("basic");

        // Back-to-back start in the cycle after done, plus a stray start while busy.
        launch(0, t0);
        repeat (49) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 1000);
        repeat (20) @(negedge clk);
        frame_end(0, t0, 679, "back-to-back");
        check_dst_values("back-to-back");

        // Pause held T+10..T+100: row 0 completes, row 1 starts after the drop.
        launch(0, t0);
        repeat (9) @(negedge clk);
        pause_req[0] = 1'b1;
        repeat (91) @(negedge clk);
        pause_req[0] = 1'b0;
        wait_done(0, 1000);
        @(negedge clk);
        frame_end(0, t0, 754, "pause");
        check_int("pause first run length", first_run[0], W);
        check_int("pause pool_valid runs", runs[0], 2);
        check_int("pause src_rd_en last", rd_last[0] - t0, 751);
        check_dst_values("pause");

        // ROW_GAP=3 instance.
        launch(1, t0);
        wait_done(1, 1200);
        @(negedge clk);
        frame_end(1, t0, 679 + 75, "gap3");
        check_int("gap3 first run length", first_run[1], W);
        check_int("gap3 pool_valid runs", runs[1], W);

        // Reset mid-frame, then a clean frame.
        launch(0, t0);
        repeat (299) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero(0, "mid-frame reset");
        @(negedge clk);
        exp_q0.delete();
        check_zero(0, "held reset");
        rst_n = 1'b1;
        @(negedge clk);
        launch(0, t0);
        wait_done(0, 1000);
        @(negedge clk);
        frame_end(0, t0, 679, "after reset");
        check_dst_values("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool_frame_sequencer.md
Name: maxpool_frame_sequencer

Overview:
Frame-level controller for the 3-channel 2x2/stride-2 max-pool stage. On a start pulse it reads one DISP_WIDTH x DISP_WIDTH feature map, held as 3 packed channels per word, from a source buffer in raster order. It streams the map into the pool stage and collects the pooled (DISP_WIDTH/2)^2 results into a destination buffer. It guarantees the pool stage sees exactly DISP_WIDTH^2 beats per frame with valid contiguous inside every row, because the pool stage's internal counters depend on this. It sits between the conv-output buffer and the next layer's input buffer.

Parameters:
DATA_WIDTH, 24, bits per channel sample.
DISP_WIDTH, 26, input map width and height; must be even.
SRC_AW, 10, source buffer address width; must be at least clog2(DISP_WIDTH^2).
DST_AW, 8, destination buffer address width; must be at least clog2((DISP_WIDTH/2)^2).
ROW_GAP, 0, idle cycles inserted between input rows (0 to 15).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset; shared with the pool stage
start  in  1  frame start; sampled only in IDLE
pause_req  in  1  request to hold streaming; honoured only at row boundaries
busy  out  1  high from the first cycle after an accepted start until done
done  out  1  single-cycle pulse at frame completion
src_rd_en  out  1  source buffer read enable
src_addr  out  SRC_AW  source read address; buffer read latency is 1 cycle
src_rdata  in  3*DATA_WIDTH  {ch3,ch2,ch1}
pool_data_1/2/3  out  DATA_WIDTH each  channel data to the pool stage (slices of src_rdata)
pool_valid  out  1  data valid to the pool stage
pool_out_1/2/3  in  DATA_WIDTH each  pool stage results (combinational from the current beat)
pool_out_valid  in  1  pool stage output flag; meaningful only while pool_valid=1
dst_we  out  1  destination write enable
dst_addr  out  DST_AW  destination write address
dst_wdata  out  3*DATA_WIDTH  {out3,out2,out1}

Behaviour:
- Reset values: all outputs 0. State=IDLE. All counters 0.
- FSM states: IDLE, ROW, GAP, TAIL, DONE.
- IDLE:
  - start=1 moves to ROW.
  - src_addr=0, src_rd_en=1 and busy=1 all take effect in the next cycle.
- ROW:
  - src_rd_en=1 every cycle; src_addr increments by 1 per cycle.
  - A column counter runs 0..DISP_WIDTH-1.
  - On the last column: if this is the last row, go to TAIL.
  - Otherwise, if ROW_GAP>0 or pause_req=1, go to GAP; else stay in ROW (next row is contiguous).
- GAP:
  - src_rd_en=0.
  - Count ROW_GAP cycles, at least 1 cycle when entered for pause only.
  - Exit to ROW only when the gap count is reached and pause_req=0.
  - pause_req is never honoured mid-row.
- Pool drive:
  - pool_valid = src_rd_en delayed 1 cycle.
  - pool_data = src_rdata; no extra register, because the buffer output is already registered.
  - pool_valid is never asserted outside the frame.
- Capture:
  - Trigger: pool_valid && pool_out_valid.
  - Next cycle: dst_we=1 and dst_wdata=registered {pool_out_3,pool_out_2,pool_out_1}.
  - dst_addr starts at 0 per frame and increments after each write.
  - Exactly (DISP_WIDTH/2)^2 writes per frame; DISP_WIDTH=26 gives 169.
- TAIL:
  - src_rd_en=0.
  - Wait until the final write (index (DISP_WIDTH/2)^2-1) has been issued, then go to DONE.
- DONE:
  - done=1 for one cycle; busy=0 in that same cycle.
  - Return to IDLE. start may be accepted in the following cycle.
- Latency, ROW_GAP=0, no pause, start sampled at cycle T:
  - src_rd_en high T+1..T+676.
  - pool_valid high T+2..T+677.
  - Last dst_we at T+678.
  - done at T+679.
- start while busy is ignored; no queueing.
- Reset mid-frame: everything returns to reset values immediately. Because the pool stage shares rst_n, its counters realign and the next frame is correct.
- Width rules: src_addr wraps never; it ends at DISP_WIDTH^2-1. Counters are sized so the terminal compares are exact.

Test Plan:
- Basic frame: src word at addr a has ch1=a, ch2=a+1000, ch3=a+2000; pulse start -> 169 writes, with:
  - dst[0] ch1=27, dst[1] ch1=29, dst[168] ch1=675, dst[168] ch3=2675;
  - done at T+679 with busy low in the same cycle.
- ROW_GAP=3: same data -> identical dst contents; done at T+679+25*3; pool_valid contiguous within each row.
- pause_req held high from cycle T+10 to T+100 -> streaming stops only after column 25 of row 0; resumes at the row 1 start once pause drops; dst contents unchanged.
- start pulsed at T+50 while busy -> ignored; exactly 169 writes; a single done.
- rst_n asserted at T+300, released, then a new start -> first frame aborted with all outputs 0; second frame dst matches the basic-frame values.
- Back-to-back: start the cycle after done -> second frame identical to the first; dst_addr restarts at 0.
